ahbl_sample_fifo: RTL and testbench

AHB-lite slave that buffers audio samples from the I2S deserializer and presents them to the CPU as a register-mapped FIFO. It sits directly downstream of the I2S receive path and is decoded by the peripheral splitter alongside the GPIO, timer and I2S slots. It absorbs bursty CPU servicing with a sample FIFO, sticky overflow/underflow flags and a level-threshold interrupt.

---
 rtl/sample_fifo_pkg.sv | 30 +++
 rtl/sample_fifo.sv | 60 ++++++
 rtl/ahbl_sample_fifo.sv | 199 +++++++++++++++++++
 tb/tb_ahbl_sample_fifo.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sample_fifo_pkg.sv
// Shared register map, STATUS/CTRL bit positions and CTRL layout
// for the AHB-lite audio sample FIFO.
package sample_fifo_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_LEVEL_W = 9;
  localparam int ST_EMPTY   = 9;
  localparam int ST_FULL    = 10;
  localparam int ST_OVF     = 11;
  localparam int ST_UDF     = 12;

  localparam int CT_EN     = 0;
  localparam int CT_FLUSH  = 1;
  localparam int CT_IE     = 2;
  localparam int CT_DECIM  = 3;
  localparam int CT_THRESH = 8;
  localparam int THRESH_W  = 8;

  typedef struct packed {
    logic                en;
    logic                ie;
    logic                decim;
    logic [THRESH_W-1:0] thresh;
  } ctrl_t;

endpackage

// File: rtl/sample_fifo.sv
// Generic synchronous FIFO with flush, full/empty and occupancy level.
// Storage is not reset; pointers wrap modulo DEPTH.
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign rdata   = mem[rp];
  // A full FIFO still accepts a push when the head leaves the same cycle
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      if (do_push & ~do_pop)
        cnt <= cnt + 1'b1;
      else if (do_pop & ~do_push)
        cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push & ~flush)
      mem[wp] <= wdata;
  end

endmodule

// File: rtl/ahbl_sample_fifo.sv
// AHB-lite register front end for the I2S sample FIFO: decode, flags, IRQ.
// Optional pair-averaging decimator enabled by SAMPLE_FIFO_DECIM_EN.
module ahbl_sample_fifo
  import sample_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SW    = 24
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic          HREADY,
  input  logic [31:0]   HWDATA,
  output logic          HREADYOUT,
  output logic [31:0]   HRDATA,
  input  logic [SW-1:0] SMP_DATA,
  input  logic          SMP_VALID,
  output logic          IRQ
);

  localparam int AW = $clog2(DEPTH);

  logic       dp_act;
  logic       dp_wr;
  logic [1:0] dp_reg;

  ctrl_t ctrl;
  logic  ovf;
  logic  udf;

  logic          rd_data;
  logic          wr_status;
  logic          wr_ctrl;
  logic          pop;
  logic          push;
  logic          flush;
  logic          ovf_set;
  logic          udf_set;
  logic [SW-1:0] push_data;

  logic [SW-1:0] head;
  logic          full;
  logic          empty;
  logic [AW:0]   level;

  logic [ST_LEVEL_W-1:0] lvl9;
  logic signed [SW-1:0]  head_s;
  logic [31:0]           head_ext;
  logic [31:0]           status;
  logic [31:0]           ctrl_rd;

  logic unused;
  assign unused = ^{HSIZE, HADDR[31:4], HADDR[1:0],
                    HWDATA[31:16], HWDATA[7:3]};

  assign HREADYOUT = 1'b1;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_act <= 1'b0;
      dp_wr  <= 1'b0;
      dp_reg <= '0;
    end else if (HREADY) begin
      dp_act <= HSEL & HTRANS[1];
      dp_wr  <= HWRITE;
      dp_reg <= HADDR[3:2];
    end
  end

  assign rd_data   = dp_act & ~dp_wr & (dp_reg == REG_DATA);
  assign wr_status = dp_act & dp_wr & (dp_reg == REG_STATUS);
  assign wr_ctrl   = dp_act & dp_wr & (dp_reg == REG_CTRL);
  assign flush     = wr_ctrl & HWDATA[CT_FLUSH];
  assign pop       = rd_data & ~empty;
  assign udf_set   = rd_data & empty;
  assign ovf_set   = push & full & ~pop & ~flush;

`ifdef SAMPLE_FIFO_DECIM_EN
  logic          phase;
  logic [SW-1:0] first;
  logic [SW:0]   sum;

  // Sign-extended SW+1-bit add; bits [SW:1] give (a+b)>>>1 truncated
  assign sum = {first[SW-1], first} + {SMP_DATA[SW-1], SMP_DATA};

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      phase <= 1'b0;
      first <= '0;
    end else if (flush | ~ctrl.en | ~ctrl.decim) begin
      phase <= 1'b0;
    end else if (SMP_VALID) begin
      phase <= ~phase;
      if (~phase) first <= SMP_DATA;
    end
  end

  assign push      = SMP_VALID & ctrl.en & (~ctrl.decim | phase);
  assign push_data = ctrl.decim ? sum[SW:1] : SMP_DATA;
`else
  assign push      = SMP_VALID & ctrl.en;
  assign push_data = SMP_DATA;
`endif

  sample_fifo #(
    .DEPTH (DEPTH),
    .W     (SW)
  ) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (push_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      ctrl.en     <= HWDATA[CT_EN];
      ctrl.ie     <= HWDATA[CT_IE];
`ifdef SAMPLE_FIFO_DECIM_EN
      ctrl.decim  <= HWDATA[CT_DECIM];
`else
      ctrl.decim  <= 1'b0;
`endif
      ctrl.thresh <= HWDATA[CT_THRESH +: THRESH_W];
    end
  end

  // Hardware set beats a same-cycle write-1-to-clear
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (ovf_set)
        ovf <= 1'b1;
      else if (wr_status & HWDATA[ST_OVF])
        ovf <= 1'b0;
      if (udf_set)
        udf <= 1'b1;
      else if (wr_status & HWDATA[ST_UDF])
        udf <= 1'b0;
    end
  end

  assign lvl9 = ST_LEVEL_W'(level);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)
      IRQ <= 1'b0;
    else
      IRQ <= ctrl.ie & (lvl9 >= ST_LEVEL_W'(ctrl.thresh))
           & (ctrl.thresh != '0);
  end

  assign head_s   = head;
  assign head_ext = 32'(head_s);

  always_comb begin
    status = '0;
    status[ST_LEVEL_W-1:0] = lvl9;
    status[ST_EMPTY]       = empty;
    status[ST_FULL]        = full;
    status[ST_OVF]         = ovf;
    status[ST_UDF]         = udf;
  end

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CT_EN]    = ctrl.en;
    ctrl_rd[CT_IE]    = ctrl.ie;
    ctrl_rd[CT_DECIM] = ctrl.decim;
    ctrl_rd[CT_THRESH +: THRESH_W] = ctrl.thresh;
  end

  always_comb begin
    HRDATA = '0;
    if (dp_act & ~dp_wr) begin
      case (dp_reg)
        REG_DATA:   HRDATA = empty ? '0 : head_ext;
        REG_STATUS: HRDATA = status;
        REG_CTRL:   HRDATA = ctrl_rd;
        default:    HRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahbl_sample_fifo.sv
// Directed bench for ahbl_sample_fifo (DEPTH=16, SW=24).
// Decimator checks run when SAMPLE_FIFO_DECIM_EN is defined.
module tb_ahbl_sample_fifo;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = '0;
  logic [2:0]  HSIZE = 3'd2;
  logic        HWRITE = 1'b0;
  logic        HREADY = 1'b1;
  logic [31:0] HWDATA = '0;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic [23:0] SMP_DATA = '0;
  logic        SMP_VALID = 1'b0;
  logic        IRQ;

  int total = 0;
  int bad = 0;
  logic [31:0] rd;

  localparam logic [31:0] A_DATA = 32'h0;
  localparam logic [31:0] A_STAT = 32'h4;
  localparam logic [31:0] A_CTRL = 32'h8;
  localparam logic [31:0] A_RSVD = 32'hC;

  ahbl_sample_fifo #(.DEPTH(16), .SW(24)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HWDATA    (HWDATA),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .SMP_DATA  (SMP_DATA),
    .SMP_VALID (SMP_VALID),
    .IRQ       (IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic ahb_wr(input logic [31:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    tick();
  endtask

  task automatic ahb_rd(input logic [31:0] a, output logic [31:0] d,
                        input bit sp, input logic [23:0] sd);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00;
    if (sp) begin
      SMP_DATA = sd;
      SMP_VALID = 1'b1;
    end
    d = HRDATA;
    tick();
    SMP_VALID = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    ahb_rd(a, d, 1'b0, '0);
    chk(tag, d, exp);
  endtask

  task automatic push(input logic [23:0] d);
    SMP_DATA = d;
    SMP_VALID = 1'b1;
    tick();
    SMP_VALID = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_hready", {31'b0, HREADYOUT}, 32'h1);
    chk("rst_irq", {31'b0, IRQ}, 32'h0);
    rd_chk("rst_status", A_STAT, 32'h200);
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rsvd", A_RSVD, 32'h0);

    ahb_wr(A_CTRL, 32'h1);
    push(24'h7FFFFF);
    push(24'h800000);
    push(24'h000001);
    rd_chk("lvl3", A_STAT, 32'h003);
    rd_chk("d_pos", A_DATA, 32'h007FFFFF);
    rd_chk("d_neg", A_DATA, 32'hFF800000);
    rd_chk("d_one", A_DATA, 32'h00000001);
    rd_chk("empty", A_STAT, 32'h200);

    ahb_wr(A_CTRL, 32'h0);
    push(24'h000005);
    rd_chk("en_off", A_STAT, 32'h200);
    ahb_wr(A_CTRL, 32'h1);

    for (int i = 1; i <= 17; i++) push(24'(i));
    rd_chk("full_ovf", A_STAT, 32'hC10);
    ahb_wr(A_STAT, 32'h800);
    rd_chk("ovf_clr", A_STAT, 32'h410);
    ahb_wr(A_RSVD, 32'hFFFFFFFF);
    rd_chk("rsvd_wr", A_CTRL, 32'h1);

    ahb_rd(A_DATA, rd, 1'b1, 24'h000100);
    chk("sim_head", rd, 32'h1);
    rd_chk("sim_stat", A_STAT, 32'h410);
    for (int i = 2; i <= 16; i++)
      rd_chk("drain", A_DATA, 32'(i));
    rd_chk("sim_tail", A_DATA, 32'h100);
    rd_chk("drained", A_STAT, 32'h200);

    rd_chk("udf_data", A_DATA, 32'h0);
    rd_chk("udf_stat", A_STAT, 32'h1200);
    ahb_wr(A_STAT, 32'h1000);
    rd_chk("udf_clr", A_STAT, 32'h200);

    ahb_wr(A_CTRL, 32'h0405);
    push(24'd10);
    push(24'd20);
    push(24'd30);
    tick();
    chk("irq_lvl3", {31'b0, IRQ}, 32'h0);
    push(24'd40);
    chk("irq_lag", {31'b0, IRQ}, 32'h0);
    tick();
    chk("irq_lvl4", {31'b0, IRQ}, 32'h1);
    rd_chk("irq_pop", A_DATA, 32'd10);
    chk("irq_hold", {31'b0, IRQ}, 32'h1);
    tick();
    chk("irq_lvl3b", {31'b0, IRQ}, 32'h0);

    ahb_wr(A_CTRL, 32'h0407);
    rd_chk("flush", A_STAT, 32'h200);
    rd_chk("flush_rd0", A_CTRL, 32'h0405);

`ifdef SAMPLE_FIFO_DECIM_EN
    ahb_wr(A_CTRL, 32'h9);
    rd_chk("dec_ctrl", A_CTRL, 32'h9);
    push(24'h000010);
    rd_chk("dec_half", A_STAT, 32'h200);
    push(24'h000020);
    rd_chk("dec_one", A_STAT, 32'h001);
    rd_chk("dec_avg", A_DATA, 32'h18);
    push(24'hFFFFFF);
    push(24'h000000);
    rd_chk("dec_neg", A_DATA, 32'hFFFFFFFF);
    push(24'h000010);
    ahb_wr(A_CTRL, 32'hB);
    push(24'h000020);
    rd_chk("dec_flush", A_STAT, 32'h200);
`else
    ahb_wr(A_CTRL, 32'h9);
    rd_chk("nodec_ctrl", A_CTRL, 32'h1);
    push(24'h000010);
    rd_chk("nodec_lvl", A_STAT, 32'h001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
